// File: rtl/video_stream_gen.sv
// video_stream_gen: raster timing generator with a selectable 8-bit luma test
// pattern. Every output is registered one clock after the counter state it
// decodes. Optional build macro VSG_FRAME_SCROLL_EN adds a per-frame
// horizontal scroll to the ramp and checker patterns.
module video_stream_gen #(
   parameter int unsigned H_ACTIVE = 1280,
   parameter int unsigned H_FP     = 110,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 220,
   parameter int unsigned V_ACTIVE = 720,
   parameter int unsigned V_FP     = 5,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 20,
   parameter int unsigned SYNC_POL = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] pattern,
   input  logic [7:0] const_y,
   output logic       ycbcr_vs,
   output logic       ycbcr_hs,
   output logic       ycbcr_de,
   output logic [7:0] ycbcr_y,
   output logic       frame_done,
   output logic       busy
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned HW = $clog2(H_TOTAL);
   localparam int unsigned VW = $clog2(V_TOTAL);
   localparam int unsigned H_ACT_START = H_SYNC + H_BP;
   localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
   localparam int unsigned V_ACT_START = V_SYNC + V_BP;
   localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;
   // Level driven on vs/hs outside the sync interval and during reset/idle.
   localparam logic SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic [1:0]      pat_q, pat_d;
   logic [7:0]      cy_q, cy_d;
   logic            vs_q, vs_d, hs_q, hs_d, de_q, de_d;
   logic [7:0]      y_q, y_d;
   logic            fd_q, fd_d, busy_q, busy_d;
`ifdef VSG_FRAME_SCROLL_EN
   logic [7:0]      fcnt_q, fcnt_d;
`endif

   logic            hs_i, vs_i, de_i, h_last, v_last, last_px;
   logic [7:0]      x8, xs8, yl8, pix;

   // Decode counter state into timing flags, pixel coordinates and pattern value.
   always_comb begin
      hs_i    = 32'(h_cnt_q) < H_SYNC;
      vs_i    = 32'(v_cnt_q) < V_SYNC;
      de_i    = (32'(h_cnt_q) >= H_ACT_START) && (32'(h_cnt_q) < H_ACT_END) &&
                (32'(v_cnt_q) >= V_ACT_START) && (32'(v_cnt_q) < V_ACT_END);
      h_last  = 32'(h_cnt_q) == H_TOTAL - 1;
      v_last  = 32'(v_cnt_q) == V_TOTAL - 1;
      last_px = h_last && v_last;
      x8      = 8'(32'(h_cnt_q) - H_ACT_START);
      yl8     = 8'(32'(v_cnt_q) - V_ACT_START);
`ifdef VSG_FRAME_SCROLL_EN
      xs8     = x8 + fcnt_q;
`else
      xs8     = x8;
`endif
      case (pat_q)
         2'd0:    pix = xs8;
         2'd1:    pix = yl8;
         2'd2:    pix = (xs8[3] ^ yl8[3]) ? 8'hFF : 8'h00;
         default: pix = cy_q;
      endcase
   end

   // Next-state, counter advance, pattern latching and registered-output values.
   always_comb begin
      state_d = state_q;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      pat_d   = pat_q;
      cy_d    = cy_q;
      vs_d    = SYNC_IDLE;
      hs_d    = SYNC_IDLE;
      de_d    = 1'b0;
      y_d     = '0;
      fd_d    = 1'b0;
      busy_d  = 1'b0;
`ifdef VSG_FRAME_SCROLL_EN
      fcnt_d  = fcnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (en) begin
               state_d = ST_RUN;
               pat_d   = pattern;
               cy_d    = const_y;
            end
         end
         default: begin
            busy_d = 1'b1;
            hs_d   = hs_i ^ SYNC_IDLE;
            vs_d   = vs_i ^ SYNC_IDLE;
            de_d   = de_i;
            y_d    = de_i ? pix : 8'h00;
            fd_d   = last_px;
            if (h_last) begin
               h_cnt_d = '0;
               v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end else begin
               h_cnt_d = h_cnt_q + 1'b1;
            end
            if (last_px) begin
`ifdef VSG_FRAME_SCROLL_EN
               fcnt_d = fcnt_q + 8'd1;
`endif
               if (en) begin
                  pat_d = pattern;
                  cy_d  = const_y;
               end else begin
                  state_d = ST_IDLE;
`ifdef VSG_FRAME_SCROLL_EN
                  fcnt_d  = '0;
`endif
               end
            end
         end
      endcase
   end

   // State, counters, latched pattern settings and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         pat_q   <= '0;
         cy_q    <= '0;
         vs_q    <= SYNC_IDLE;
         hs_q    <= SYNC_IDLE;
         de_q    <= 1'b0;
         y_q     <= '0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
`ifdef VSG_FRAME_SCROLL_EN
         fcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         pat_q   <= pat_d;
         cy_q    <= cy_d;
         vs_q    <= vs_d;
         hs_q    <= hs_d;
         de_q    <= de_d;
         y_q     <= y_d;
         fd_q    <= fd_d;
         busy_q  <= busy_d;
`ifdef VSG_FRAME_SCROLL_EN
         fcnt_q  <= fcnt_d;
`endif
      end
   end

   assign ycbcr_vs   = vs_q;
   assign ycbcr_hs   = hs_q;
   assign ycbcr_de   = de_q;
   assign ycbcr_y    = y_q;
   assign frame_done = fd_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: two instances (small active-high geometry and a
// 16x16 active-low geometry) share one randomized stimulus stream and are
// compared every cycle against a frame-position model.
module tb_video_stream_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [1:0] pattern = 2'd0;
   logic [7:0] const_y = 8'd0;

   logic       vs_a, hs_a, de_a, fd_a, busy_a;
   logic [7:0] y_a;
   logic       vs_b, hs_b, de_b, fd_b, busy_b;
   logic [7:0] y_b;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   video_stream_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .pattern(pattern), .const_y(const_y),
      .ycbcr_vs(vs_a), .ycbcr_hs(hs_a), .ycbcr_de(de_a), .ycbcr_y(y_a),
      .frame_done(fd_a), .busy(busy_a)
   );

   video_stream_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .pattern(pattern), .const_y(const_y),
      .ycbcr_vs(vs_b), .ycbcr_hs(hs_b), .ycbcr_de(de_b), .ycbcr_y(y_b),
      .frame_done(fd_b), .busy(busy_b)
   );

   typedef struct { int hs; int hb; int ha; int hf; int vs; int vb; int va; int vf; bit pol; } geo_t;
   typedef struct { bit run; int pos; int pat; int cy; int fcnt; } mst_t;
   typedef struct { bit vs; bit hs; bit de; bit fd; bit busy; logic [7:0] y; } out_t;

   geo_t ga, gb;
   mst_t ma, mb;
   out_t exp_a, exp_b;

   function automatic int frame_len(input geo_t g);
      return (g.hs + g.hb + g.ha + g.hf) * (g.vs + g.vb + g.va + g.vf);
   endfunction

   function automatic out_t idle_out(input geo_t g);
      out_t o;
      o.vs = !g.pol; o.hs = !g.pol; o.de = 0; o.fd = 0; o.busy = 0; o.y = 8'h00;
      return o;
   endfunction

   // Outputs for one position within a running frame.
   function automatic out_t decode(input geo_t g, input int pos, input int pat, input int cy, input int fcnt);
      out_t o;
      int ht, h, v, x, yl, xs, val;
      ht = g.hs + g.hb + g.ha + g.hf;
      h  = pos % ht;
      v  = pos / ht;
      x  = h - (g.hs + g.hb);
      yl = v - (g.vs + g.vb);
      xs = x;
`ifdef VSG_FRAME_SCROLL_EN
      if (pat == 0 || pat == 2) xs = x + fcnt;
`endif
      o.hs   = (h < g.hs) == g.pol;
      o.vs   = (v < g.vs) == g.pol;
      o.de   = (x >= 0) && (x < g.ha) && (yl >= 0) && (yl < g.va);
      o.fd   = (pos == frame_len(g) - 1);
      o.busy = 1;
      if (!o.de)         val = 0;
      else if (pat == 0) val = xs % 256;
      else if (pat == 1) val = yl % 256;
      else if (pat == 2) val = (((xs / 8) + (yl / 8)) % 2 == 1) ? 255 : 0;
      else               val = cy;
      o.y = 8'(val);
      return o;
   endfunction

   task automatic step(input geo_t g, input mst_t mi, input bit en_i, input int pat_i, input int cy_i,
                       output mst_t mo, output out_t o);
      mo = mi;
      if (!mi.run) begin
         o = idle_out(g);
         if (en_i) begin
            mo.run = 1; mo.pos = 0; mo.pat = pat_i; mo.cy = cy_i;
         end
      end else begin
         o = decode(g, mi.pos, mi.pat, mi.cy, mi.fcnt);
         if (mi.pos == frame_len(g) - 1) begin
            mo.pos  = 0;
            mo.fcnt = (mi.fcnt + 1) % 256;
            if (en_i) begin
               mo.pat = pat_i; mo.cy = cy_i;
            end else begin
               mo.run = 0; mo.fcnt = 0;
            end
         end else begin
            mo.pos = mi.pos + 1;
         end
      end
   endtask

   // Reference model advances on the same edges the DUT registers on.
   always @(posedge clk or posedge rst) begin
      mst_t na, nb;
      if (rst) begin
         ma = '{default: 0};
         mb = '{default: 0};
         exp_a = idle_out(ga);
         exp_b = idle_out(gb);
      end else begin
         step(ga, ma, en, int'(pattern), int'(const_y), na, exp_a);
         step(gb, mb, en, int'(pattern), int'(const_y), nb, exp_b);
         ma = na;
         mb = nb;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_vs", 32'(vs_a), 32'(exp_a.vs));
         chk("a_hs", 32'(hs_a), 32'(exp_a.hs));
         chk("a_de", 32'(de_a), 32'(exp_a.de));
         chk("a_y", 32'(y_a), 32'(exp_a.y));
         chk("a_fd", 32'(fd_a), 32'(exp_a.fd));
         chk("a_busy", 32'(busy_a), 32'(exp_a.busy));
         chk("b_vs", 32'(vs_b), 32'(exp_b.vs));
         chk("b_hs", 32'(hs_b), 32'(exp_b.hs));
         chk("b_de", 32'(de_b), 32'(exp_b.de));
         chk("b_y", 32'(y_b), 32'(exp_b.y));
         chk("b_fd", 32'(fd_b), 32'(exp_b.fd));
         chk("b_busy", 32'(busy_b), 32'(exp_b.busy));
      end
   end

   task automatic wait_fd_a(input int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (fd_a !== 1'b1 && n < lim);
      chk("wait_fd_a", 32'(fd_a), 32'd1);
   endtask

   task automatic wait_de_a(input int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (de_a !== 1'b1 && n < lim);
      chk("wait_de_a", 32'(de_a), 32'd1);
   endtask

   initial begin
      out_t o;
      int n, hsc, vsc, dec;
      ga = '{2, 2, 8, 2, 1, 1, 4, 1, 1'b1};
      gb = '{2, 2, 16, 2, 1, 1, 16, 1, 1'b0};

      // Hand-computed anchors for the model itself.
      o = decode(ga, 2*14 + 4, 0, 0, 0);
      chk("pin_a_first_px_de", 32'(o.de), 32'd1);
      chk("pin_a_first_px_y", 32'(o.y), 32'd0);
      o = decode(ga, 2*14 + 11, 0, 0, 0);
      chk("pin_a_last_px_y", 32'(o.y), 32'd7);
      o = decode(ga, 0, 0, 0, 0);
      chk("pin_a_origin_sync", {30'd0, o.hs, o.vs}, 32'd3);
      o = decode(ga, 97, 0, 0, 0);
      chk("pin_a_fd", 32'(o.fd), 32'd1);
      o = decode(gb, 2*22 + 12, 2, 0, 0);
      chk("pin_b_chk_x8_r0", 32'(o.y), 32'hFF);
      o = decode(gb, 10*22 + 12, 2, 0, 0);
      chk("pin_b_chk_x8_r8", 32'(o.y), 32'h00);
      o = decode(gb, 0, 0, 0, 0);
      chk("pin_b_sync_low", {30'd0, o.hs, o.vs}, 32'd0);

      #1 rst = 1'b1;
      chk_en = 1'b1;
      #20;
      @(negedge clk);
      rst = 1'b0;
      en = 1'b1;
      pattern = 2'd0;

      // One full continuous frame on instance A: cadence and per-frame counts.
      wait_fd_a(300);
      n = 0; hsc = 0; vsc = 0; dec = 0;
      do begin
         @(negedge clk);
         n++;
         hsc += int'(hs_a); vsc += int'(vs_a); dec += int'(de_a);
      end while (fd_a !== 1'b1 && n < 300);
      chk("frame_period", 32'(n), 32'd98);
      chk("hs_count", 32'(hsc), 32'd14);
      chk("vs_count", 32'(vsc), 32'd14);
      chk("de_count", 32'(dec), 32'd32);

      // Checker frames, mostly for the 16x16 instance.
      pattern = 2'd2;
      repeat (900) @(negedge clk);

      // Constant level latched at frame start; a mid-frame change waits a frame.
      pattern = 2'd3;
      const_y = 8'h5A;
      wait_fd_a(300);
      repeat (20) @(negedge clk);
      const_y = 8'h11;
      wait_de_a(200);
      chk("const_held", 32'(y_a), 32'h5A);
      wait_fd_a(300);
      wait_de_a(200);
      chk("const_next", 32'(y_a), 32'h11);

      // Drop run request at line 3: frame completes then goes idle.
      wait_fd_a(300);
      repeat (3*14) @(negedge clk);
      en = 1'b0;
      wait_fd_a(300);
      @(negedge clk);
      chk("idle_busy", 32'(busy_a), 32'd0);
      chk("idle_de_y", {23'd0, de_a, y_a}, 32'd0);
      repeat (3) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("restart_busy", 32'(busy_a), 32'd1);
      chk("restart_sync", {30'd0, hs_a, vs_a}, 32'd3);

      // Asynchronous reset in the middle of an active pixel.
      pattern = 2'd3;
      const_y = 8'hC3;
      wait_de_a(300);
      #2 rst = 1'b1;
      #1;
      chk("rst_a_outs", {20'd0, de_a, y_a, fd_a, busy_a, hs_a, vs_a}, 32'd0);
      chk("rst_b_outs", {20'd0, de_b, y_b, fd_b, busy_b, hs_b, vs_b}, 32'd3);
      @(negedge clk);
      rst = 1'b0;

      // Randomized run: en toggles, pattern/const changes, occasional resets.
      repeat (4000) begin
         int r;
         @(negedge clk);
         r = int'($urandom_range(0, 999));
         if (r < 8) en = ~en;
         if (r >= 990) pattern = 2'($urandom_range(0, 3));
         if (r >= 980 && r < 990) const_y = 8'($urandom_range(0, 255));
         if (r == 500) begin
            #2 rst = 1'b1;
            #4 rst = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
